// File: rtl/uart_pkg.sv
// Shared constants for the UART buffering blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

  // One UART-formatted frame: start + 8 data + stop.
  localparam int FRAME_W    = 10;
  // Default receive/transmit buffer depth, in frames.
  localparam int FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/fifo_ram.sv
// Storage array for uart_fifo: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the owner gates the write enable.
module fifo_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  // Contents are deliberately not reset; validity is tracked by the owner's level.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is asynchronous so the head word falls through with no extra cycle.
  assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/uart_fifo.sv
// First-word-fall-through frame FIFO with occupancy, peak and threshold flags.
// Latency: a word pushed at edge N is presented on odata (ovalid=1) right after edge N.
// Backpressure: iready drops only at level==DEPTH; both handshakes decode registered state only.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = FRAME_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ivalid,
  output logic                       iready,
  input  logic [DATA_W-1:0]          idata,
  output logic                       ovalid,
  input  logic                       oready,
  output logic [DATA_W-1:0]          odata,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     peak,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;
  logic          ram_we;

  // Handshake readiness comes from the registered level alone, so a pop in the
  // same cycle can never open the door for a push into a full FIFO.
  assign iready = (level != LW'(DEPTH));
  assign ovalid = (level != '0);

  assign push = ivalid && iready;
  assign pop  = ovalid && oready;

  // Nothing is written during a clear: the clear wins and storage is don't-care anyway.
  assign ram_we = push && !reset && !flush;

  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointer, level and peak registers; reset and flush clear identically.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      peak   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      if (level_nxt > peak) begin
        peak <= level_nxt;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (idata),
    .raddr (rd_ptr),
    .rdata (odata)
  );

endmodule : uart_fifo

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed scenarios plus a long randomized run,
// every cycle compared against a queue-based reference of the FIFO behaviour.
// Clock period 10; inputs change 1 time unit after the rising edge.
module tb_uart_fifo;

  localparam int DW    = 10;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          ivalid;
  logic          iready;
  logic [DW-1:0] idata;
  logic          ovalid;
  logic          oready;
  logic [DW-1:0] odata;
  logic [LW-1:0] level;
  logic [LW-1:0] peak;
  logic          almost_full;
  logic          almost_empty;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: contents in order, and the highest occupancy seen.
  logic [DW-1:0] mq[$];
  int            m_peak = 0;

  always #5 clk = ~clk;

  uart_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .ivalid       (ivalid),
    .iready       (iready),
    .idata        (idata),
    .ovalid       (ovalid),
    .oready       (oready),
    .odata        (odata),
    .level        (level),
    .peak         (peak),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Compare every observable output with the reference for the current state.
  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("level",        32'(level),        32'(sz));
    chk("peak",         32'(peak),         32'(m_peak));
    chk("iready",       32'(iready),       32'(sz != DEPTH));
    chk("ovalid",       32'(ovalid),       32'(sz != 0));
    chk("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    if (sz != 0) begin
      chk("odata", 32'(odata), 32'(mq[0]));
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the reference, clock,
  // then advance the reference by the FIFO rules.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy,
                     input logic fl, input logic rs);
    bit do_push;
    bit do_pop;
    ivalid = iv;
    idata  = id;
    oready = ordy;
    flush  = fl;
    reset  = rs;
    check_model();
    do_push = iv && (mq.size() != DEPTH);
    do_pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    if (rs || fl) begin
      mq.delete();
      m_peak = 0;
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(id);
      if (mq.size() > m_peak) m_peak = mq.size();
    end
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1'b1, DW'(base + i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b0;
    ivalid = 1'b0;
    oready = 1'b0;
    idata  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Post-reset values.
    chk("rst_iready", 32'(iready),       32'd1);
    chk("rst_ovalid", 32'(ovalid),       32'd0);
    chk("rst_level",  32'(level),        32'd0);
    chk("rst_peak",   32'(peak),         32'd0);
    chk("rst_ae",     32'(almost_empty), 32'd1);
    chk("rst_af",     32'(almost_full),  32'd0);

    // Fill and drain.
    push_n(16, 1);
    chk("fill_iready", 32'(iready),      32'd0);
    chk("fill_level",  32'(level),       32'd16);
    chk("fill_af",     32'(almost_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(odata), 32'(i + 1));
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_ovalid", 32'(ovalid), 32'd0);

    // Streaming wrap: 40 words with both sides always ready.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(10'h100 + i), 1'b1, 1'b0, 1'b0);
      chk("wrap_level", 32'(level), 32'd1);
    end
    pop_n(1);

    // Full boundary: a pop in the same cycle does not admit the push.
    push_n(16, 10'h040);
    cyc(1'b1, 10'h155, 1'b1, 1'b0, 1'b0);
    chk("full_pop_level", 32'(level), 32'd15);
    cyc(1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
    chk("full_refill_level", 32'(level), 32'd16);
    pop_n(16);
    chk("full_last", 32'(ovalid), 32'd0);

    // Flush with a concurrent push; peak built to 9 first.
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    mq.delete();
    m_peak = 0;
    push_n(9, 10'h080);
    pop_n(4);
    chk("pre_flush_level", 32'(level), 32'd5);
    chk("pre_flush_peak",  32'(peak),  32'd9);
    cyc(1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0);
    chk("flush_level",  32'(level),  32'd0);
    chk("flush_peak",   32'(peak),   32'd0);
    chk("flush_ovalid", 32'(ovalid), 32'd0);

    // Reset mid-fill, then first push after release is the head.
    push_n(7, 10'h0C0);
    cyc(1'b1, 10'h111, 1'b1, 1'b0, 1'b1);
    chk("rst2_iready", 32'(iready),       32'd1);
    chk("rst2_level",  32'(level),        32'd0);
    chk("rst2_peak",   32'(peak),         32'd0);
    chk("rst2_ae",     32'(almost_empty), 32'd1);
    chk("rst2_af",     32'(almost_full),  32'd0);
    cyc(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0);
    chk("rst2_ovalid", 32'(ovalid), 32'd1);
    chk("rst2_odata",  32'(odata),  32'h2AA);

    // Randomized traffic with shifting bias, occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      int bias_in;
      int bias_out;
      bias_in  = ((i / 500) % 2 == 0) ? 70 : 35;
      bias_out = ((i / 500) % 2 == 0) ? 35 : 70;
      cyc(($urandom_range(99) < bias_in)  ? 1'b1 : 1'b0,
          DW'($urandom),
          ($urandom_range(99) < bias_out) ? 1'b1 : 1'b0,
          ($urandom_range(399) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(999) == 0) ? 1'b1 : 1'b0);
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_uart_fifo

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, giving the data width in bits (one UART-formatted frame).
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of entries; it SHALL be a power of two, 2..256.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, giving the almost-full level.
REQ-004 The block SHALL have parameter AE_THRESH, default 2, giving the almost-empty level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-008 The block SHALL have port ivalid, input, 1 bit: the producer has a word on idata.
REQ-009 The block SHALL have port iready, output, 1 bit: the FIFO can accept a word.
REQ-010 The block SHALL have port idata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port ovalid, output, 1 bit: odata holds a valid word.
REQ-012 The block SHALL have port oready, input, 1 bit: the consumer takes odata.
REQ-013 The block SHALL have port odata, output, DATA_W bits: head-of-queue data.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-015 The block SHALL have port peak, output, $clog2(DEPTH)+1 bits: highest level since the last reset or flush.
REQ-016 The block SHALL have ports almost_full and almost_empty, output, 1 bit each: threshold flags.

Function
REQ-017 A push SHALL occur on a clock edge with ivalid && iready; a pop SHALL occur on a clock edge with ovalid && oready.
REQ-018 iready SHALL equal (level != DEPTH) and ovalid SHALL equal (level != 0), both decoded from registered state only, with no combinational path from ivalid or oready.
REQ-019 All DEPTH entries SHALL be usable: the full condition SHALL be level == DEPTH, not DEPTH-1.
REQ-020 The output SHALL be first-word-fall-through: odata equals the entry at the read pointer whenever ovalid is 1, and a word pushed at edge N SHALL appear with ovalid=1 after edge N.
REQ-021 When ovalid is 0, odata SHALL be don't-care.
REQ-022 Write and read pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH without a gap.
REQ-023 On a push only, level SHALL increment by 1; on a pop only, level SHALL decrement by 1; on a simultaneous push and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full, a push SHALL be impossible because iready=0, even if a pop occurs in the same cycle; the freed slot SHALL be accepted on the next cycle.
REQ-025 When empty, a pop SHALL be impossible; a same-cycle push SHALL be stored and presented on the next cycle, with no bypass.
REQ-026 almost_full SHALL equal (level >= AF_THRESH) and almost_empty SHALL equal (level <= AE_THRESH), both derived from registered level.
REQ-027 peak SHALL be updated to the next level whenever the next level exceeds peak.
REQ-028 flush=1 SHALL set the pointers, level and peak to 0 at the next edge, SHALL override any push or pop in that cycle, and SHALL leave the storage contents undefined.
REQ-029 Pushes when full and pops when empty SHALL not corrupt the pointers or level.

Reset
REQ-030 reset SHALL take priority over flush and have the same effect.
REQ-031 After reset, outputs SHALL be: iready=1, ovalid=0, level=0, peak=0, almost_empty=1, almost_full=0.
REQ-032 Storage SHALL not be reset.
REQ-033 reset asserted mid-transfer SHALL discard all contents, and the first push after reset release SHALL be the next word read.

Structure
REQ-034 Package uart_pkg SHALL hold FRAME_W=10 and the default FIFO_DEPTH, used as the parameter defaults.
REQ-035 One sub-module, fifo_ram, SHALL hold the storage: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
REQ-036 The pointers, level, peak and flag logic SHALL reside in uart_fifo.

Verification
REQ-037 Fill and drain test (DEPTH=16): push 16 words 0x001..0x010 with oready=0 -> iready=0 after the 16th, level=16, almost_full=1; then drain -> 0x001..0x010 in order, ovalid=0 after the last.
REQ-038 Wrap test: 40 streaming words with ivalid=oready=1 held constant -> level stays 1 after the first word, output order is exact, and the pointers wrap twice.
REQ-039 Full-boundary test: at level=16 drive ivalid=1 and oready=1 -> a pop occurs, the word is not accepted, level=15; next cycle the word is accepted and level=16.
REQ-040 Flush test: at level=5 with peak=9, assert flush together with a push -> next cycle level=0, peak=0, ovalid=0, and the pushed word is lost.
REQ-041 Reset test: at level=7, pulse reset for 1 cycle -> the REQ-031 values hold; push 0x2AA -> odata=0x2AA with ovalid=1 on the following cycle.
REQ-042 Random test: a randomized ivalid/oready bench run against a queue model for 10k cycles -> zero data mismatches, and level and flags always match the model.
